iir_coeff_loader: RTL and testbench

Coefficient writer for the IIR filter datapath. It accepts coefficient words one at a time over a valid/ready handshake and collects them in shadow registers. It then commits the full set atomically to packed `o_coeff_b` / `o_coeff_a` buses that drive the filter's coefficient inputs directly. The block sits between the control/host side and the filter, so the filter never sees a partially updated coefficient set.

---
 rtl/iir_coeff_loader.sv | 130 +++++++++++++
 tb/tb_iir_coeff_loader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coeff_loader.sv
`default_nettype none
// ============================================================================
//  Module   : iir_coeff_loader
//  Brief    : Collects IIR coefficient words into shadow registers over a
//             valid/ready handshake, then commits the complete B/A set to the
//             active coefficient buses in a single edge, so the filter never
//             sees a partially updated set.
//  Revision : 1.0 - initial release
// ============================================================================
module iir_coeff_loader #(
    parameter int NB_COEFF = 16,
    parameter int N_COEFFS = 3,
    parameter int NB_CNT   = $clog2(2*N_COEFFS)
) (
    input  logic                             clock,
    input  logic                             i_reset,
    input  logic                             i_valid,
    input  logic [NB_COEFF-1:0]              i_data,
    output logic                             o_ready,
    input  logic                             i_abort,
    input  logic                             i_hold,
    output logic [NB_COEFF*N_COEFFS-1:0]     o_coeff_b,
    output logic [NB_COEFF*(N_COEFFS-1)-1:0] o_coeff_a,
    output logic                             o_update,
    output logic                             o_busy,
    output logic [NB_CNT-1:0]                o_word_cnt
);

    // Index of the final word of a set (a(N-2)); accepting it closes the load.
    localparam logic [NB_CNT-1:0] c_LAST_IDX = NB_CNT'(2*N_COEFFS-2);

    // Pass-through set: b0 = largest positive fraction, everything else zero.
    localparam logic [NB_COEFF*N_COEFFS-1:0] c_PASS_B =
        {{(NB_COEFF*(N_COEFFS-1)){1'b0}}, 1'b0, {(NB_COEFF-1){1'b1}}};

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                             r_state;
    state_t                             w_next_state;
    logic                               w_ready;
    logic                               w_accept;
    logic                               w_commit;
    logic [NB_CNT-1:0]                  r_word_cnt;
    logic [NB_COEFF*N_COEFFS-1:0]       r_shadow_b;
    logic [NB_COEFF*(N_COEFFS-1)-1:0]   r_shadow_a;
    logic [NB_COEFF*N_COEFFS-1:0]       r_coeff_b;
    logic [NB_COEFF*(N_COEFFS-1)-1:0]   r_coeff_a;
    logic                               r_update;

    // State register.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; abort overrides both accept and commit.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_ready  = 1'b1;
                w_accept = i_valid & ~i_abort;
                if (w_accept && (r_word_cnt == c_LAST_IDX)) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_commit = ~i_hold & ~i_abort;
                if (i_abort || w_commit) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // Word counter, shadow capture, atomic commit and the update pulse.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_word_cnt <= '0;
            r_shadow_b <= '0;
            r_shadow_a <= '0;
            r_coeff_b  <= c_PASS_B;
            r_coeff_a  <= '0;
            r_update   <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (i_abort) begin
                r_word_cnt <= '0;
            end else if (w_accept) begin
                r_word_cnt <= r_word_cnt + NB_CNT'(1);
                for (int i = 0; i < N_COEFFS; i++) begin
                    if (r_word_cnt == NB_CNT'(i)) begin
                        r_shadow_b[i*NB_COEFF +: NB_COEFF] <= i_data;
                    end
                end
                for (int i = 0; i < N_COEFFS-1; i++) begin
                    if (r_word_cnt == NB_CNT'(N_COEFFS+i)) begin
                        r_shadow_a[i*NB_COEFF +: NB_COEFF] <= i_data;
                    end
                end
            end else if (w_commit) begin
                r_word_cnt <= '0;
                r_coeff_b  <= r_shadow_b;
                r_coeff_a  <= r_shadow_a;
                r_update   <= 1'b1;
            end
        end
    end

    assign o_ready    = w_ready;
    assign o_coeff_b  = r_coeff_b;
    assign o_coeff_a  = r_coeff_a;
    assign o_update   = r_update;
    assign o_word_cnt = r_word_cnt;
    assign o_busy     = (r_word_cnt != '0) | (r_state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_iir_coeff_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_coeff_loader
//  Brief    : Self-checking bench for iir_coeff_loader. Stimulus pushes each
//             coefficient set expected to commit; a monitor pops and compares
//             on every o_update pulse and flags coefficient changes without
//             an update.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iir_coeff_loader;

    logic        clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_ready;
    logic        i_abort = 1'b0;
    logic        i_hold = 1'b0;
    logic [47:0] o_coeff_b;
    logic [31:0] o_coeff_a;
    logic        o_update;
    logic        o_busy;
    logic [2:0]  o_word_cnt;

    int checks = 0;
    int errors = 0;

    logic [47:0] q_b[$];
    logic [31:0] q_a[$];

    localparam logic [47:0] c_PASS_B = 48'h0000_0000_7FFF;

    iir_coeff_loader #(.NB_COEFF(16), .N_COEFFS(3), .NB_CNT(3)) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_abort    (i_abort),
        .i_hold     (i_hold),
        .o_coeff_b  (o_coeff_b),
        .o_coeff_a  (o_coeff_a),
        .o_update   (o_update),
        .o_busy     (o_busy),
        .o_word_cnt (o_word_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Present one word and hold it until accepted, bounded.
    task automatic send_word(input logic [15:0] d);
        int n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("ready_timeout", 64'(o_ready), 64'(1));
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
        i_data  = 16'hDEAD;
    endtask

    task automatic push_set(input logic [15:0] w0, w1, w2, w3, w4);
        q_b.push_back({w2, w1, w0});
        q_a.push_back({w4, w3});
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_abort = 1'b0;
        i_hold  = 1'b0;
        idle(2);
        i_reset = 1'b0;
    endtask

    // Monitor: compare every commit against the scoreboard queue.
    logic [47:0] prev_b = '0;
    logic [31:0] prev_a = '0;
    logic        prev_upd = 1'b0;
    always @(negedge clock) begin
        if (o_update === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL spurious_update: got b=%h a=%h expected no commit", o_coeff_b, o_coeff_a);
            end else begin
                logic [47:0] eb;
                logic [31:0] ea;
                eb = q_b.pop_front();
                ea = q_a.pop_front();
                if (o_coeff_b !== eb || o_coeff_a !== ea) begin
                    errors++;
                    $display("FAIL commit_set: got b=%h a=%h expected b=%h a=%h", o_coeff_b, o_coeff_a, eb, ea);
                end
            end
            if (prev_upd) begin
                checks++;
                errors++;
                $display("FAIL update_width: got 2+ cycle pulse expected 1 cycle");
            end
        end
        if (!i_reset && (o_coeff_b !== prev_b || o_coeff_a !== prev_a)) begin
            checks++;
            if (o_update !== 1'b1) begin
                errors++;
                $display("FAIL coeff_change: got change to b=%h a=%h expected change only with o_update", o_coeff_b, o_coeff_a);
            end
        end
        prev_b   = o_coeff_b;
        prev_a   = o_coeff_a;
        prev_upd = (o_update === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        do_reset();
        chk("rst_b",     64'(o_coeff_b),  64'(c_PASS_B));
        chk("rst_a",     64'(o_coeff_a),  64'(0));
        chk("rst_ready", 64'(o_ready),    64'(1));
        chk("rst_upd",   64'(o_update),   64'(0));
        chk("rst_busy",  64'(o_busy),     64'(0));
        chk("rst_cnt",   64'(o_word_cnt), 64'(0));

        // Back-to-back load, no hold.
        push_set(16'h1000, 16'h2000, 16'h1000, 16'hC000, 16'h2000);
        send_word(16'h1000);
        chk("b2b_cnt1", 64'(o_word_cnt), 64'(1));
        chk("b2b_busy1", 64'(o_busy), 64'(1));
        send_word(16'h2000);
        send_word(16'h1000);
        send_word(16'hC000);
        send_word(16'h2000);
        chk("wait_ready", 64'(o_ready),    64'(0));
        chk("wait_busy",  64'(o_busy),     64'(1));
        chk("wait_cnt",   64'(o_word_cnt), 64'(5));
        chk("wait_upd",   64'(o_update),   64'(0));
        chk("wait_b_old", 64'(o_coeff_b),  64'(c_PASS_B));
        tick();
        chk("cm_upd",   64'(o_update),   64'(1));
        chk("cm_ready", 64'(o_ready),    64'(1));
        chk("cm_b",     64'(o_coeff_b),  64'(48'h1000_2000_1000));
        chk("cm_a",     64'(o_coeff_a),  64'(32'h2000_C000));
        chk("cm_cnt",   64'(o_word_cnt), 64'(0));
        chk("cm_busy",  64'(o_busy),     64'(0));
        tick();
        chk("cm_upd_end", 64'(o_update), 64'(0));

        // Gapped valid, plus words offered during a held WAIT.
        push_set(16'h1000, 16'h2000, 16'h1000, 16'hC000, 16'h2000);
        begin
            logic [15:0] w[5];
            w = '{16'h1000, 16'h2000, 16'h1000, 16'hC000, 16'h2000};
            for (int k = 0; k < 5; k++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    i_data = 16'hBEEF;
                    tick();
                end
                chk("gap_cnt_pre", 64'(o_word_cnt), 64'(k));
                if (k == 4) i_hold = 1'b1;
                send_word(w[k]);
            end
        end
        i_valid = 1'b1;
        i_data  = 16'h5555;
        idle(3);
        chk("junk_cnt", 64'(o_word_cnt), 64'(5));
        i_hold = 1'b0;
        tick();
        i_valid = 1'b0;
        chk("junk_upd", 64'(o_update),   64'(1));
        chk("junk_b",   64'(o_coeff_b),  64'(48'h1000_2000_1000));
        chk("junk_a",   64'(o_coeff_a),  64'(32'h2000_C000));
        chk("junk_cnt0", 64'(o_word_cnt), 64'(0));
        tick();

        // Hold for 10 cycles after the last word.
        push_set(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500);
        send_word(16'h0100);
        send_word(16'h0200);
        send_word(16'h0300);
        send_word(16'h0400);
        i_hold = 1'b1;
        send_word(16'h0500);
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 9) begin
                chk("hold_b",     64'(o_coeff_b), 64'(48'h1000_2000_1000));
                chk("hold_ready", 64'(o_ready),   64'(0));
                chk("hold_busy",  64'(o_busy),    64'(1));
            end
            tick();
        end
        i_hold = 1'b0;
        tick();
        chk("hold_upd", 64'(o_update),  64'(1));
        chk("hold_b2",  64'(o_coeff_b), 64'(48'h0300_0200_0100));
        chk("hold_a2",  64'(o_coeff_a), 64'(32'h0500_0400));
        tick();

        // Abort after three words, then a fresh set.
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort3_cnt",  64'(o_word_cnt), 64'(0));
        chk("abort3_busy", 64'(o_busy),     64'(0));
        push_set(16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        send_word(16'h4000);
        send_word(16'h0000);
        send_word(16'h0000);
        send_word(16'h0000);
        send_word(16'h0000);
        tick();
        chk("abort3_b", 64'(o_coeff_b), 64'(48'h0000_0000_4000));
        chk("abort3_a", 64'(o_coeff_a), 64'(0));
        tick();

        // Abort coinciding with an accept: word dropped.
        send_word(16'h0AAA);
        send_word(16'h0BBB);
        i_abort = 1'b1;
        send_word(16'h0CCC);
        i_abort = 1'b0;
        chk("abort_acc_cnt", 64'(o_word_cnt), 64'(0));
        push_set(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055);
        send_word(16'h0011);
        send_word(16'h0022);
        send_word(16'h0033);
        send_word(16'h0044);
        send_word(16'h0055);
        tick();
        chk("abort_acc_b", 64'(o_coeff_b), 64'(48'h0033_0022_0011));
        chk("abort_acc_a", 64'(o_coeff_a), 64'(32'h0055_0044));
        tick();

        // Abort during WAIT beats the commit.
        send_word(16'h7000);
        send_word(16'h7001);
        send_word(16'h7002);
        send_word(16'h7003);
        send_word(16'h7004);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_wait_upd",   64'(o_update),   64'(0));
        chk("abort_wait_b",     64'(o_coeff_b),  64'(48'h0033_0022_0011));
        chk("abort_wait_cnt",   64'(o_word_cnt), 64'(0));
        chk("abort_wait_ready", 64'(o_ready),    64'(1));
        idle(2);

        // Reset mid-load.
        send_word(16'h1234);
        send_word(16'h5678);
        do_reset();
        chk("rst_mid_b",   64'(o_coeff_b),  64'(c_PASS_B));
        chk("rst_mid_cnt", 64'(o_word_cnt), 64'(0));

        // Reset during a held WAIT.
        send_word(16'h0101);
        send_word(16'h0202);
        send_word(16'h0303);
        send_word(16'h0404);
        i_hold = 1'b1;
        send_word(16'h0505);
        do_reset();
        chk("rst_wait_b",     64'(o_coeff_b),  64'(c_PASS_B));
        chk("rst_wait_a",     64'(o_coeff_a),  64'(0));
        chk("rst_wait_cnt",   64'(o_word_cnt), 64'(0));
        chk("rst_wait_ready", 64'(o_ready),    64'(1));

        // Full load after reset commits correctly.
        push_set(16'h1000, 16'h2000, 16'h1000, 16'hC000, 16'h2000);
        send_word(16'h1000);
        send_word(16'h2000);
        send_word(16'h1000);
        send_word(16'hC000);
        send_word(16'h2000);
        tick();
        chk("post_rst_b", 64'(o_coeff_b), 64'(48'h1000_2000_1000));
        chk("post_rst_a", 64'(o_coeff_a), 64'(32'h2000_C000));
        idle(3);

        chk("sb_drained", 64'(q_b.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
